// File: rtl/regfile_dump_reader_pkg.sv
// rtl/regfile_dump_reader_pkg.sv - shared sizes, FSM encoding and byte-select helper for the dump reader
package regfile_dump_reader_pkg;

  localparam int REG_ADDR_W     = 5;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } dump_state_t;

  // Byte k of a word, counting from the most significant byte.
  function automatic logic [7:0] word_byte(input logic [WORD_W-1:0] word,
                                           input logic [BYTE_IDX_W-1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dump_byte_serializer.sv
// rtl/dump_byte_serializer.sv - shadows one register word and streams it out MSB byte first
module dump_byte_serializer
  import regfile_dump_reader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [WORD_W-1:0] word,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              last_byte_accepted
);

  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  logic [WORD_W-1:0]     shadow;
  logic [BYTE_IDX_W-1:0] byte_idx;
  logic                  valid_q;
  logic                  handshake;

  // A clear in the same cycle as ready means the byte was not sent.
  assign handshake          = valid_q && out_ready && !clear;
  assign last_byte_accepted = handshake && (byte_idx == LAST_BYTE);
  assign out_valid          = valid_q;
  assign out_data           = word_byte(shadow, byte_idx);

  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow   <= '0;
      byte_idx <= '0;
      valid_q  <= 1'b0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      shadow   <= word;
      byte_idx <= '0;
      valid_q  <= 1'b1;
    end else if (handshake) begin
      if (byte_idx == LAST_BYTE) begin
        valid_q <= 1'b0;
      end else begin
        byte_idx <= byte_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks register indices through a spare read port and dumps them as a byte stream
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic [REG_ADDR_W-1:0] rf_addr,
  input  logic [WORD_W-1:0]     rf_data,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  freeze_req,
  output logic                  busy,
  output logic                  done
);

  localparam logic [REG_ADDR_W-1:0] FIRST_IDX = REG_ADDR_W'(FIRST_REG);
  localparam logic [REG_ADDR_W-1:0] LAST_IDX  = REG_ADDR_W'(LAST_REG);

  dump_state_t           state, state_next;
  logic [REG_ADDR_W-1:0] reg_idx;
  logic                  done_q;
  logic                  load;
  logic                  clear;
  logic                  last_accepted;
  logic [WORD_W-1:0]     fetch_word;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   state_next = abort ? IDLE : SEND;
      SEND: begin
        if (abort) begin
          state_next = IDLE;
        end else if (last_accepted) begin
          state_next = (reg_idx == LAST_IDX) ? DONE : FETCH;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    freeze_req = busy;
    load       = (state == FETCH) && !abort;
    clear      = abort && (state != IDLE);
  end

  // The terminal compare happens before the increment, so the 5-bit index never wraps.
  always_ff @(posedge clk) begin
    if (!reset) begin
      reg_idx <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == DONE) && !abort;
      if (state == IDLE && start) begin
        reg_idx <= FIRST_IDX;
      end else if (state == SEND && !abort && last_accepted && reg_idx != LAST_IDX) begin
        reg_idx <= reg_idx + 1'b1;
      end
    end
  end

  assign fetch_word = (reg_idx == '0) ? '0 : rf_data;
  assign rf_addr    = reg_idx;
  assign done       = done_q;

  dump_byte_serializer u_serializer (
    .clk                (clk),
    .reset              (reset),
    .load               (load),
    .clear              (clear),
    .word               (fetch_word),
    .out_data           (out_data),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .last_byte_accepted (last_accepted)
  );

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb/tb_regfile_dump_reader.sv - directed table-driven bench for the register-file dump reader
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b1;
  logic [4:0]  rf_addr, rf_addr2;
  logic [31:0] rf_data, rf_data2;
  logic [7:0]  out_data, out_data2;
  logic        out_valid, out_valid2, freeze_req, freeze_req2, busy, busy2, done, done2;
  logic [31:0] regs [32];

  assign rf_data  = regs[rf_addr];
  assign rf_data2 = regs[rf_addr2];

  regfile_dump_reader #(.FIRST_REG(0), .LAST_REG(31)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .rf_addr(rf_addr), .rf_data(rf_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .freeze_req(freeze_req), .busy(busy), .done(done)
  );

  regfile_dump_reader #(.FIRST_REG(4), .LAST_REG(4)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .abort(abort),
    .rf_addr(rf_addr2), .rf_data(rf_data2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
    .freeze_req(freeze_req2), .busy(busy2), .done(done2)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endtask

  logic [7:0] cap[$];
  logic [7:0] cap2[$];
  int         done_cnt = 0;
  int         done2_cnt = 0;
  int         done_cyc = -1;
  int         first_valid_cyc = -1;
  int         c0 = 0;
  logic       prev_pend = 1'b0;
  logic       prev_excused = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (prev_pend && !prev_excused) begin
      check1("hold_valid", out_valid, 1'b1);
      check("hold_data", {24'd0, out_data}, {24'd0, prev_data});
    end
    prev_pend    = out_valid && !out_ready;
    prev_data    = out_data;
    prev_excused = abort || !reset;
    if (out_valid && out_ready && !abort && reset) cap.push_back(out_data);
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (out_valid2 && out_ready && reset) cap2.push_back(out_data2);
    if (done2) done2_cnt++;
  end

  typedef struct {
    int          idx;
    logic [31:0] val;
    logic [7:0]  e0, e1, e2, e3;
  } vec_t;

  vec_t tbl [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dump();
    cap.delete();
    done_cnt = 0;
    done_cyc = -1;
    first_valid_cyc = -1;
    start = 1'b1;
    c0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick();
    if (done_cnt == 0) check(name, 32'd0, 32'd1);
  endtask

  function automatic int dump_errors();
    int e = 0;
    for (int i = 0; i < 128; i++) begin
      logic [31:0] w;
      logic [7:0]  b;
      w = regs[i / 4];
      b = 8'(w >> (8 * (3 - (i % 4))));
      if (i >= cap.size() || cap[i] !== b) e++;
    end
    return e;
  endfunction

  task automatic check_dump(input string tag);
    check({tag, "_bytes"}, 32'(cap.size()), 32'd128);
    check({tag, "_bad_bytes"}, 32'(dump_errors()), 32'd0);
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    for (int k = 0; k < 5; k++) begin
      int base;
      base = 4 * tbl[k].idx;
      if (cap.size() < base + 4) begin
        check($sformatf("%s_reg%0d_size", tag, tbl[k].idx), 32'(cap.size()), 32'(base + 4));
      end else begin
        check($sformatf("%s_reg%0d_b0", tag, tbl[k].idx), {24'd0, cap[base]},     {24'd0, tbl[k].e0});
        check($sformatf("%s_reg%0d_b1", tag, tbl[k].idx), {24'd0, cap[base + 1]}, {24'd0, tbl[k].e1});
        check($sformatf("%s_reg%0d_b2", tag, tbl[k].idx), {24'd0, cap[base + 2]}, {24'd0, tbl[k].e2});
        check($sformatf("%s_reg%0d_b3", tag, tbl[k].idx), {24'd0, cap[base + 3]}, {24'd0, tbl[k].e3});
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0,  32'h00000000, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[1] = '{1,  32'h11223344, 8'h11, 8'h22, 8'h33, 8'h44};
    tbl[2] = '{5,  32'hA5C30F96, 8'hA5, 8'hC3, 8'h0F, 8'h96};
    tbl[3] = '{7,  32'h01020304, 8'h01, 8'h02, 8'h03, 8'h04};
    tbl[4] = '{31, 32'hDEADBEEF, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    for (int k = 0; k < 5; k++) regs[tbl[k].idx] = tbl[k].val;

    // Reset state
    repeat (3) tick();
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_freeze", freeze_req, 1'b0);
    check1("rst_done", done, 1'b0);
    check("rst_rf_addr", {27'd0, rf_addr}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    reset = 1'b1;
    tick();

    // Full dump, ready always high
    start_dump();
    check1("t1_busy_after_start", busy, 1'b1);
    check1("t1_freeze_after_start", freeze_req, 1'b1);
    check("t1_fetch_addr", {27'd0, rf_addr}, 32'd0);
    wait_done("t1_done_timeout", 400);
    repeat (3) tick();
    check_dump("t1");
    check("t1_first_valid_latency", 32'(first_valid_cyc - c0), 32'd2);
    check("t1_done_latency", 32'(done_cyc - c0), 32'd162);
    check1("t1_busy_after", busy, 1'b0);
    check1("t1_freeze_after", freeze_req, 1'b0);

    // Same dump with random back-pressure
    ready_mode = 1;
    start_dump();
    wait_done("t2_done_timeout", 3000);
    ready_mode = 0;
    repeat (3) tick();
    check_dump("t2");

    // start re-pulsed while sending reg 5
    start_dump();
    for (int i = 0; i < 200; i++) begin
      if (rf_addr == 5'd5 && out_valid) break;
      tick();
    end
    check("t3_reached_reg5", {27'd0, rf_addr}, 32'd5);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t3_done_timeout", 400);
    repeat (3) tick();
    check_dump("t3");

    // abort with the third byte of reg 7 pending
    start_dump();
    for (int i = 0; i < 300; i++) begin
      if (cap.size() == 30) break;
      tick();
    end
    check("t4_bytes_before_abort", 32'(cap.size()), 32'd30);
    check("t4_abort_addr", {27'd0, rf_addr}, 32'd7);
    check("t4_pending_byte", {24'd0, out_data}, 32'h03);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check1("t4_out_valid", out_valid, 1'b0);
    check1("t4_busy", busy, 1'b0);
    check1("t4_freeze", freeze_req, 1'b0);
    repeat (5) tick();
    check("t4_no_done", 32'(done_cnt), 32'd0);
    check("t4_bytes_after_abort", 32'(cap.size()), 32'd30);
    start_dump();
    wait_done("t4_restart_timeout", 400);
    repeat (3) tick();
    check_dump("t4_restart");

    // reset low with the clock stopped, then one clocked reset edge mid-SEND
    start_dump();
    for (int i = 0; i < 200; i++) begin
      if (rf_addr == 5'd3 && out_valid) break;
      tick();
    end
    clk_en = 1'b0;
    reset = 1'b0;
    #50;
    check1("t5_stopped_busy", busy, 1'b1);
    check1("t5_stopped_valid", out_valid, 1'b1);
    check("t5_stopped_addr", {27'd0, rf_addr}, 32'd3);
    clk_en = 1'b1;
    tick();
    check("t5_rf_addr", {27'd0, rf_addr}, 32'd0);
    check("t5_out_data", {24'd0, out_data}, 32'd0);
    check1("t5_out_valid", out_valid, 1'b0);
    check1("t5_busy", busy, 1'b0);
    check1("t5_freeze", freeze_req, 1'b0);
    check1("t5_done", done, 1'b0);
    reset = 1'b1;
    repeat (5) tick();
    check("t5_no_done", 32'(done_cnt), 32'd0);

    // single-register window FIRST_REG = LAST_REG = 4
    regs[4] = 32'hCAFEF00D;
    cap2.delete();
    done2_cnt = 0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("t6_fetch_addr", {27'd0, rf_addr2}, 32'd4);
    check1("t6_busy", busy2, 1'b1);
    for (int i = 0; i < 30 && done2_cnt == 0; i++) tick();
    if (done2_cnt == 0) check("t6_done_timeout", 32'd0, 32'd1);
    repeat (2) tick();
    check("t6_bytes", 32'(cap2.size()), 32'd4);
    if (cap2.size() >= 4) begin
      check("t6_b0", {24'd0, cap2[0]}, 32'hCA);
      check("t6_b1", {24'd0, cap2[1]}, 32'hFE);
      check("t6_b2", {24'd0, cap2[2]}, 32'hF0);
      check("t6_b3", {24'd0, cap2[3]}, 32'h0D);
    end
    check("t6_done_cnt", 32'(done2_cnt), 32'd1);
    check1("t6_busy_after", busy2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
